// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming k_size x k_size sliding-window generator fed row-major, backed by k_size-1 line buffers
module conv_window_gen #(
   parameter int k_size = 5,
   parameter int img_w  = 28,
   parameter int img_h  = 28
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_pixel,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] win [0:k_size-1][0:k_size-1],
   output logic        frame_done
);
   localparam int CW = $clog2(img_w);
   localparam int RW = $clog2(img_h);
   localparam logic [CW-1:0] COL_LAST = CW'(img_w - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(img_h - 1);
   localparam logic [CW-1:0] COL_WIN  = CW'(k_size - 1);
   localparam logic [RW-1:0] ROW_WIN  = RW'(k_size - 1);

   logic [15:0]   lb    [0:k_size-2][0:img_w-1];
   logic [15:0]   win_q [0:k_size-1][0:k_size-1];
   logic [15:0]   win_d [0:k_size-1][0:k_size-1];
   logic [15:0]   v     [0:k_size-1];
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          out_valid_q, out_valid_d;
   logic          frame_done_q, frame_done_d;
   logic          acc;

   assign in_ready   = out_ready | ~out_valid_q;
   assign acc        = in_valid & in_ready;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;
   assign win        = win_q;

   // column vector entering the window: buffered rows above, current pixel at the bottom
   always_comb begin
      for (int i = 0; i < k_size - 1; i++) v[i] = lb[i][col_q];
      v[k_size-1] = in_pixel;
   end

   // next state: shift window left on accept, advance raster position, flag complete windows
   always_comb begin
      win_d        = win_q;
      col_d        = col_q;
      row_d        = row_q;
      out_valid_d  = out_valid_q & ~out_ready;
      frame_done_d = 1'b0;
      if (acc) begin
         for (int i = 0; i < k_size; i++) begin
            for (int j = 0; j < k_size - 1; j++) win_d[i][j] = win_q[i][j+1];
            win_d[i][k_size-1] = v[i];
         end
         col_d        = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
         row_d        = (col_q != COL_LAST) ? row_q : (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         out_valid_d  = (row_q >= ROW_WIN) && (col_q >= COL_WIN);
         frame_done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
      end
   end

   // state registers; reset discards any pending window and restarts at pixel (0,0)
   always_ff @(posedge clk) begin
      if (rst) begin
         win_q        <= '{default: '0};
         col_q        <= '0;
         row_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         win_q        <= win_d;
         col_q        <= col_d;
         row_q        <= row_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // line buffers move up one row per accepted column; reads see pre-write contents
   always_ff @(posedge clk) begin
      if (acc) for (int i = 0; i < k_size - 1; i++) lb[i][col_q] <= v[i+1];
   end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: scoreboard bench for a 3x3/5x4 instance and a default 5x5/28x28 instance
module tb_conv_window_gen;
   localparam int K = 3, W = 5, H = 4, NA = K*K*16;
   localparam int K2 = 5, W2 = 28, H2 = 28, NB = K2*K2*16;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic        iv_a = 1'b0, ordy_a = 1'b1, ir_a, ov_a, fd_a;
   logic [15:0] px_a = '0;
   logic [15:0] win_a [0:K-1][0:K-1];
   logic        iv_b = 1'b0, ordy_b = 1'b1, ir_b, ov_b, fd_b;
   logic [15:0] px_b = '0;
   logic [15:0] win_b [0:K2-1][0:K2-1];

   conv_window_gen #(.k_size(K), .img_w(W), .img_h(H)) dut_a (
      .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_pixel(px_a),
      .out_valid(ov_a), .out_ready(ordy_a), .win(win_a), .frame_done(fd_a));

   conv_window_gen dut_b (
      .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_pixel(px_b),
      .out_valid(ov_b), .out_ready(ordy_b), .win(win_b), .frame_done(fd_b));

   int n_tests = 0, n_fail = 0;
   logic [NA-1:0] qa [$];
   bit            la [$];
   logic [NB-1:0] qb [$];
   bit            lq_b [$];
   int pops_a = 0, fds_a = 0, pops_b = 0, fds_b = 0, stall_a = 0;
   logic [15:0] fa [W*H];
   logic [15:0] fb [W2*H2];

   task automatic chk(input bit ok, input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference window: plain 2-D crop of the frame ending at (r,c)
   function automatic logic [NA-1:0] ref_a(input int r, input int c);
      logic [NA-1:0] w = '0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++) w[(i*K+j)*16 +: 16] = fa[(r-K+1+i)*W + (c-K+1+j)];
      return w;
   endfunction

   function automatic logic [NB-1:0] ref_b(input int r, input int c);
      logic [NB-1:0] w = '0;
      for (int i = 0; i < K2; i++)
         for (int j = 0; j < K2; j++) w[(i*K2+j)*16 +: 16] = fb[(r-K2+1+i)*W2 + (c-K2+1+j)];
      return w;
   endfunction

   // monitor A: compare presented window to scoreboard head, pop on consume
   always @(negedge clk) begin : mon_a
      logic [NA-1:0] got;
      if (!rst) begin
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) got[(i*K+j)*16 +: 16] = win_a[i][j];
         if (fd_a) fds_a++;
         if (ov_a) begin
            if (qa.size() == 0) chk(1'b0, "a_spurious_window", got, 0);
            else begin
               chk(got == qa[0], "a_window", got, qa[0]);
               if (fd_a) chk(la[0], "a_frame_done_on_last", 0, 1);
               if (!ordy_a) chk(ir_a == 1'b0, "a_in_ready_stall", ir_a, 0);
               if (ordy_a) begin
                  void'(qa.pop_front());
                  void'(la.pop_front());
                  pops_a++;
               end
            end
         end else begin
            chk(ir_a == 1'b1, "a_in_ready_idle", ir_a, 1);
            if (fd_a) chk(1'b0, "a_frame_done_no_window", fd_a, 0);
         end
      end
   end

   // monitor B: same checks on the default-size instance
   always @(negedge clk) begin : mon_b
      logic [NB-1:0] got;
      if (!rst) begin
         for (int i = 0; i < K2; i++)
            for (int j = 0; j < K2; j++) got[(i*K2+j)*16 +: 16] = win_b[i][j];
         if (fd_b) fds_b++;
         if (ov_b) begin
            if (qb.size() == 0) chk(1'b0, "b_spurious_window", got, 0);
            else begin
               chk(got == qb[0], "b_window", got, qb[0]);
               if (fd_b) chk(lq_b[0], "b_frame_done_on_last", 0, 1);
               if (!ordy_b) chk(ir_b == 1'b0, "b_in_ready_stall", ir_b, 0);
               if (ordy_b) begin
                  void'(qb.pop_front());
                  void'(lq_b.pop_front());
                  pops_b++;
               end
            end
         end else if (fd_b) chk(1'b0, "b_frame_done_no_window", fd_b, 0);
      end
   end

   task automatic fill_a(input bit rnd, input logic [15:0] base);
      for (int i = 0; i < W*H; i++) fa[i] = rnd ? 16'($urandom) : base + 16'(i);
   endtask

   // drive one frame into A; pv/pr are in_valid/out_ready percentages
   task automatic send_a(input int pv, input int pr, input int rst_at, input bit stall);
      int idx = 0, guard = 0, r, c;
      while (idx < W*H && guard < 4000) begin
         @(posedge clk); #1;
         ordy_a = (stall_a > 0) ? 1'b0 : ($urandom_range(99) < pr);
         if (stall_a > 0) stall_a--;
         iv_a = ($urandom_range(99) < pv);
         px_a = fa[idx];
         #1;
         guard++;
         if (iv_a && ir_a) begin
            r = idx / W;
            c = idx % W;
            if (r >= K-1 && c >= K-1) begin
               qa.push_back(ref_a(r, c));
               la.push_back(idx == W*H-1);
            end
            if (stall && idx == (K-1)*W + K-1) stall_a = 4;
            if (idx == rst_at) begin
               @(posedge clk); #1;
               iv_a = 1'b0;
               rst = 1'b1;
               @(posedge clk); #1;
               rst = 1'b0;
               qa.delete();
               la.delete();
               chk(ov_a == 1'b0, "a_reset_out_valid", ov_a, 0);
               chk(fd_a == 1'b0, "a_reset_frame_done", fd_a, 0);
               return;
            end
            idx++;
         end
      end
      chk(idx == W*H, "a_send_timeout", idx, W*H);
   endtask

   task automatic drain_a();
      int g = 0;
      @(posedge clk); #1;
      iv_a = 1'b0;
      ordy_a = 1'b1;
      while (qa.size() > 0 && g < 50) begin
         @(posedge clk);
         g++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk(qa.size() == 0, "a_drain", qa.size(), 0);
   endtask

   task automatic send_b(input int pr);
      int idx = 0, guard = 0, r, c;
      while (idx < W2*H2 && guard < 8000) begin
         @(posedge clk); #1;
         ordy_b = ($urandom_range(99) < pr);
         iv_b = 1'b1;
         px_b = fb[idx];
         #1;
         guard++;
         if (iv_b && ir_b) begin
            r = idx / W2;
            c = idx % W2;
            if (r >= K2-1 && c >= K2-1) begin
               qb.push_back(ref_b(r, c));
               lq_b.push_back(idx == W2*H2-1);
            end
            idx++;
         end
      end
      chk(idx == W2*H2, "b_send_timeout", idx, W2*H2);
      @(posedge clk); #1;
      iv_b = 1'b0;
      ordy_b = 1'b1;
      guard = 0;
      while (qb.size() > 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk(qb.size() == 0, "b_drain", qb.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int p, f;
      logic [NA-1:0] z;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++) z[(i*K+j)*16 +: 16] = win_a[i][j];
      chk(ov_a == 1'b0 && ov_b == 1'b0, "reset_out_valid", ov_a, 0);
      chk(fd_a == 1'b0 && fd_b == 1'b0, "reset_frame_done", fd_a, 0);
      chk(z == '0 && win_b[K2-1][K2-1] == 16'h0, "reset_win_zero", z, 0);
      chk(ir_a == 1'b1, "reset_in_ready", ir_a, 1);
      rst = 1'b0;
      // continuous ramp frame
      fill_a(1'b0, 16'h0000);
      p = pops_a; f = fds_a;
      send_a(100, 100, -1, 1'b0);
      drain_a();
      chk(pops_a - p == 6, "s1_window_count", pops_a - p, 6);
      chk(fds_a - f == 1, "s1_frame_done_count", fds_a - f, 1);
      // downstream stall on the first window
      p = pops_a; f = fds_a;
      send_a(100, 100, -1, 1'b1);
      drain_a();
      chk(pops_a - p == 6, "s2_window_count", pops_a - p, 6);
      chk(fds_a - f == 1, "s2_frame_done_count", fds_a - f, 1);
      // random input gaps and random backpressure
      for (int t = 0; t < 3; t++) begin
         p = pops_a; f = fds_a;
         send_a(50, 50, -1, 1'b0);
         drain_a();
         chk(pops_a - p == 6, "s3_window_count", pops_a - p, 6);
         chk(fds_a - f == 1, "s3_frame_done_count", fds_a - f, 1);
      end
      // random pixel values
      fill_a(1'b1, 16'h0000);
      p = pops_a;
      send_a(70, 70, -1, 1'b0);
      drain_a();
      chk(pops_a - p == 6, "rand_window_count", pops_a - p, 6);
      // two frames back to back
      p = pops_a; f = fds_a;
      fill_a(1'b0, 16'h0000);
      send_a(100, 100, -1, 1'b0);
      fill_a(1'b0, 16'h0100);
      send_a(100, 100, -1, 1'b0);
      drain_a();
      chk(pops_a - p == 12, "s4_window_count", pops_a - p, 12);
      chk(fds_a - f == 2, "s4_frame_done_count", fds_a - f, 2);
      // reset mid-frame after pixel 13, then a full frame
      fill_a(1'b0, 16'h0000);
      send_a(100, 100, 13, 1'b0);
      p = pops_a; f = fds_a;
      send_a(100, 100, -1, 1'b0);
      drain_a();
      chk(pops_a - p == 6, "s5_window_count", pops_a - p, 6);
      chk(fds_a - f == 1, "s5_frame_done_count", fds_a - f, 1);
      // default-size instance with a ramp
      for (int i = 0; i < W2*H2; i++) fb[i] = 16'(i);
      p = pops_b; f = fds_b;
      send_b(80);
      chk(pops_b - p == 576, "s6_window_count", pops_b - p, 576);
      chk(fds_b - f == 1, "s6_frame_done_count", fds_b - f, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming sliding-window generator that sits directly upstream of the convolution unit.
- Accepts a row-major stream of 16-bit half-precision pixels for one image.
- Buffers k_size-1 previous rows in line buffers.
- Emits every k_size x k_size window (stride 1, no padding) as an unpacked 2-D array that connects straight to the convolution unit's `in` port.

Parameters:
- k_size, 5, window edge length; must be ≥2 and ≤ img_w and ≤ img_h
- img_w, 28, image width in pixels
- img_h, 28, image height in pixels

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_pixel is valid this cycle
- in_ready  output  1  block can accept in_pixel this cycle
- in_pixel  input  16  half-float pixel, row-major order, opaque (no arithmetic performed)
- out_valid  output  1  win holds a valid window
- out_ready  input  1  downstream consumes win this cycle
- win  output  16 x [0:k_size-1][0:k_size-1]  window; win[i][j] is row i (0 = top/oldest), column j (0 = leftmost)
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, frame_done=0, win all 16'h0000.
  - Column counter col=0, row counter row=0.
  - Line-buffer storage is not reset; stale data is never emitted, see below.
- in_ready = out_ready | ~out_valid. in_ready is combinational and has no dependency on in_valid.
- Accept event: in_valid & in_ready at a rising edge. Pixel p is at position (row, col).
  - Column vector: v[i] = linebuf[i][col] for i=0..k_size-2, and v[k_size-1] = p.
  - Window shift: win[i][j] <= win[i][j+1] for j<k_size-1, and win[i][k_size-1] <= v[i].
  - Line-buffer shift: linebuf[i][col] <= linebuf[i+1][col] for i<k_size-2, and linebuf[k_size-2][col] <= p. linebuf[0] holds row-(k_size-1).
  - Counters: col increments and wraps to 0 at img_w-1. row increments on col wrap and wraps to 0 after (img_h-1, img_w-1).
  - Output: out_valid <= 1 on the next edge iff row ≥ k_size-1 and col ≥ k_size-1 for the accepted pixel; otherwise out_valid <= 0. Latency is 1 cycle from accept to out_valid.
- No accept while out_valid & out_ready:
  - out_valid <= 0.
  - No accept while out_valid & ~out_ready: win and out_valid hold. No pixel is accepted because in_ready=0.
- Windows emitted per frame: (img_w-k_size+1)*(img_h-k_size+1), in raster order of their bottom-right pixel.
- frame_done: registered pulse, high exactly one cycle, on the cycle after the accept of pixel (img_h-1, img_w-1). It is coincident with out_valid rising for the last window.
- Back-to-back frames:
  - The next pixel after a wrap is (0,0) of a new frame; no idle cycle is required.
  - Rows 0..k_size-2 of the new frame produce no output.
  - Line-buffer contents are overwritten before they are used, so there is no cross-frame leakage into emitted windows.
- Stale-data rule: window columns shifted in at col < k_size-1 may contain previous-row data. They are never presented while out_valid=1.
- Reset mid-frame:
  - Counters return to (0,0), out_valid drops on the same edge, and any pending window is discarded.
  - The following pixel is treated as (0,0).
- in_valid low: state holds; gaps between pixels are arbitrary.
- Line buffers: (k_size-1)*img_w*16 bits, RAM or register inference permitted. Read and write of the same address in one accept must read the old value.

Test Plan:
1. k_size=3, img_w=5, img_h=4; pixels 16'h0000..16'h0013 (value = index), continuous in_valid, out_ready=1 → exactly 6 windows. First window, one cycle after pixel 12 is accepted: rows {0,1,2},{5,6,7},{10,11,12}. Last window: {7,8,9},{12,13,14},{17,18,19}. frame_done pulses once, coincident with the last window.
2. Same stream, out_ready held 0 for 4 cycles when the first window appears → win stays {0,1,2},{5,6,7},{10,11,12}, in_ready=0, no pixel lost. Remaining windows match scenario 1.
3. Random in_valid gaps (~50%) and random out_ready → window sequence is identical to scenario 1 and no window is duplicated.
4. Two frames back-to-back, frame 2 values = index+16'h0100 → 12 windows total. Frame-2 first window: {0x100,0x101,0x102},{0x105,0x106,0x107},{0x10A,0x10B,0x10C}. No frame-1 values appear in frame-2 windows.
5. rst asserted for 1 cycle after pixel 13 of frame 1, then the full frame restarted → out_valid=0 and frame_done=0 the cycle after reset. Subsequent output matches scenario 1 exactly.
6. Defaults (k_size=5, 28x28), ramp stream → 576 windows. Window n is checked against a reference model; frame_done asserts exactly once.
